// File: rtl/rr_onehot_arbiter.sv
// -----------------------------------------------------------------------------
// rr_onehot_arbiter
// Four-requester round-robin arbiter that shares one downstream resource.
// A granted owner keeps the resource until it signals done, drops its request,
// or has held it for MAX_HOLD consecutive cycles (forced release, flagged by a
// one-cycle timeout pulse). Every release is followed by at least one idle
// cycle. The grant is presented both one-hot and encoded.
//
// Parameters:
//   MAX_HOLD    - maximum consecutive grant cycles per owner (1..255), 0 = off
// Ports:
//   clk         - rising-edge clock
//   rst         - asynchronous active-high reset
//   req[3:0]    - request lines, req[i] high = client i wants the resource
//   done        - owner releases the grant (only looked at while granted)
//   grant[3:0]  - registered one-hot grant, zero when idle
//   grant_idx   - registered encoded owner, meaningful while grant_valid=1
//   grant_valid - registered, high while a grant is held
//   timeout     - registered one-cycle pulse on a forced release
// -----------------------------------------------------------------------------
module rr_onehot_arbiter #(
  parameter int MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       done,
  output logic [3:0] grant,
  output logic [1:0] grant_idx,
  output logic       grant_valid,
  output logic       timeout
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD);

  state_t     state_q, state_d;
  logic [1:0] last_q, last_d;
  logic [7:0] hold_cnt_q, hold_cnt_d;
  logic [3:0] grant_q, grant_d;
  logic [1:0] grant_idx_q, grant_idx_d;
  logic       grant_valid_q, grant_valid_d;
  logic       timeout_q, timeout_d;

  logic [2:0] pick_s;        // {found, index}
  logic       hold_limit_s;
  logic       owner_req_s;
  logic       release_s;

  // Round-robin search starting just after the last owner; returns {found, idx}.
  function automatic logic [2:0] rr_pick(input logic [3:0] req_v,
                                         input logic [1:0] last_v);
    logic [1:0] c1, c2, c3, c4;
    c1 = last_v + 2'd1;
    c2 = last_v + 2'd2;
    c3 = last_v + 2'd3;
    c4 = last_v;
    if (req_v[c1]) begin
      return {1'b1, c1};
    end else if (req_v[c2]) begin
      return {1'b1, c2};
    end else if (req_v[c3]) begin
      return {1'b1, c3};
    end else if (req_v[c4]) begin
      return {1'b1, c4};
    end else begin
      return 3'b000;
    end
  endfunction

  assign pick_s       = rr_pick(req, last_q);
  assign hold_limit_s = (MAX_HOLD != 0) && (hold_cnt_q == HOLD_LIM);
  assign owner_req_s  = req[grant_idx_q];
  assign release_s    = done | ~owner_req_s | hold_limit_s;

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      last_q        <= 2'd3;
      hold_cnt_q    <= 8'd0;
      grant_q       <= 4'b0000;
      grant_idx_q   <= 2'd0;
      grant_valid_q <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_q        <= last_d;
      hold_cnt_q    <= hold_cnt_d;
      grant_q       <= grant_d;
      grant_idx_q   <= grant_idx_d;
      grant_valid_q <= grant_valid_d;
      timeout_q     <= timeout_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (pick_s[2]) begin
          state_d = GRANT;
        end else begin
          state_d = IDLE;
        end
      end
      GRANT: begin
        if (release_s) begin
          state_d = IDLE;
        end else begin
          state_d = GRANT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs, history and hold counter.
  always_comb begin
    last_d        = last_q;
    hold_cnt_d    = hold_cnt_q;
    grant_d       = grant_q;
    grant_idx_d   = grant_idx_q;
    grant_valid_d = grant_valid_q;
    timeout_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_s[2]) begin
          grant_d       = 4'b0001 << pick_s[1:0];
          grant_idx_d   = pick_s[1:0];
          grant_valid_d = 1'b1;
          hold_cnt_d    = 8'd1;
        end else begin
          grant_d       = 4'b0000;
          grant_valid_d = 1'b0;
          hold_cnt_d    = 8'd0;
        end
      end
      GRANT: begin
        if (release_s) begin
          grant_d       = 4'b0000;
          grant_valid_d = 1'b0;
          last_d        = grant_idx_q;
          hold_cnt_d    = 8'd0;
          // Only a release caused purely by the hold limit counts as forced.
          timeout_d     = hold_limit_s & ~done & owner_req_s;
        end else begin
          if (hold_cnt_q != 8'hFF) begin
            hold_cnt_d = hold_cnt_q + 8'd1;
          end else begin
            hold_cnt_d = hold_cnt_q;
          end
        end
      end
      default: begin
        grant_d       = 4'b0000;
        grant_valid_d = 1'b0;
        hold_cnt_d    = 8'd0;
      end
    endcase
  end

  assign grant       = grant_q;
  assign grant_idx   = grant_idx_q;
  assign grant_valid = grant_valid_q;
  assign timeout     = timeout_q;

endmodule

// File: tb/tb_rr_onehot_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rr_onehot_arbiter
// Directed self-checking bench for rr_onehot_arbiter with MAX_HOLD = 8.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_rr_onehot_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic       done;
  logic [3:0] grant;
  logic [1:0] grant_idx;
  logic       grant_valid;
  logic       timeout;

  int checks;
  int failures;

  rr_onehot_arbiter #(.MAX_HOLD(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .done        (done),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid),
    .timeout     (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".grant"}, {4'd0, grant}, 8'h00);
    chk({tag, ".valid"}, {7'd0, grant_valid}, 8'h00);
    chk({tag, ".timeout"}, {7'd0, timeout}, 8'h00);
  endtask

  task automatic chk_grant(input string tag, input logic [3:0] g, input logic [1:0] idx);
    chk({tag, ".grant"}, {4'd0, grant}, {4'd0, g});
    chk({tag, ".idx"}, {6'd0, grant_idx}, {6'd0, idx});
    chk({tag, ".valid"}, {7'd0, grant_valid}, 8'h01);
    chk({tag, ".timeout"}, {7'd0, timeout}, 8'h00);
  endtask

  logic [3:0] rr_g [5];
  logic [1:0] rr_i [5];

  initial begin
    checks   = 0;
    failures = 0;
    rr_g[0] = 4'b0001; rr_i[0] = 2'd0;
    rr_g[1] = 4'b0010; rr_i[1] = 2'd1;
    rr_g[2] = 4'b0100; rr_i[2] = 2'd2;
    rr_g[3] = 4'b1000; rr_i[3] = 2'd3;
    rr_g[4] = 4'b0001; rr_i[4] = 2'd0;

    // Reset values
    rst  = 1'b1;
    req  = 4'b0000;
    done = 1'b0;
    step();
    step();
    chk_idle("reset");
    chk("reset.idx", {6'd0, grant_idx}, 8'h00);
    rst = 1'b0;

    // No requests for 5 cycles
    for (int i = 0; i < 5; i++) begin
      step();
      chk_idle("noreq");
    end

    // All requesting, done pulsed while each grant is visible
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      step();
      chk_grant("rr", rr_g[i], rr_i[i]);
      done = 1'b1;
      if (i == 4) begin
        req = 4'b0000;
      end else begin
        req = 4'b1111;
      end
      step();
      chk_idle("rr_rel");
      done = 1'b0;
    end

    // Single requester held: forced release after exactly 8 cycles
    req = 4'b0100;
    step();
    chk_grant("hold1", 4'b0100, 2'd2);
    for (int i = 0; i < 7; i++) begin
      step();
      chk_grant("hold", 4'b0100, 2'd2);
    end
    step();
    chk("to.grant", {4'd0, grant}, 8'h00);
    chk("to.valid", {7'd0, grant_valid}, 8'h00);
    chk("to.timeout", {7'd0, timeout}, 8'h01);
    step();
    chk_grant("to_regrant", 4'b0100, 2'd2);

    // Owner 1 drops request while client 3 requests
    done = 1'b1;
    req  = 4'b0000;
    step();
    chk_idle("t4_rel");
    done = 1'b0;
    req  = 4'b0010;
    step();
    chk_grant("t4_own1", 4'b0010, 2'd1);
    req = 4'b1000;
    step();
    chk_idle("t4_drop");
    step();
    chk_grant("t4_own3", 4'b1000, 2'd3);

    // done on the same edge the hold limit is reached: normal release
    for (int i = 0; i < 7; i++) begin
      step();
      chk_grant("t5_hold", 4'b1000, 2'd3);
    end
    done = 1'b1;
    step();
    chk_idle("t5_done_at_limit");
    done = 1'b0;
    req  = 4'b0000;
    step();
    chk_idle("t5_idle");

    // Build history last=2, then grant 1 and reset mid-grant
    req = 4'b0100;
    step();
    chk_grant("t6_own2", 4'b0100, 2'd2);
    done = 1'b1;
    step();
    chk_idle("t6_rel2");
    done = 1'b0;
    req  = 4'b0010;
    step();
    chk_grant("t6_own1", 4'b0010, 2'd1);
    #2;
    rst = 1'b1;
    #1;
    chk_idle("t6_async_rst");
    chk("t6_async_rst.idx", {6'd0, grant_idx}, 8'h00);
    step();
    rst = 1'b0;
    req = 4'b1010;
    step();
    chk_grant("t6_after_rst", 4'b0010, 2'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rr_onehot_arbiter.md
Name: rr_onehot_arbiter

Overview:
- Four-requester round-robin arbiter with grant hold, release and a hold timeout.
- Shares one downstream resource, such as the shared encoder/decoder datapath, between four clients.
- Presents each grant two ways: one-hot (grant) and 2-bit encoded (grant_idx).
- Sits between the client request lines and the resource's select input.

Parameters:
- MAX_HOLD, 8, maximum consecutive cycles one owner may hold the grant. Range 1..255. 0 disables the timeout.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- req  input  4  request lines; req[i] high means client i wants the resource.
- done  input  1  owner releases the grant; sampled only while grant_valid=1.
- grant  output  4  registered one-hot grant; all-zero when idle.
- grant_idx  output  2  registered encoded owner index; valid only while grant_valid=1.
- grant_valid  output  1  registered; high while a grant is held.
- timeout  output  1  registered 1-cycle pulse on a forced release.

Behaviour:
- Clocking and reset:
  - One clock, clk.
  - rst is asynchronous and active-high, and takes effect immediately at any time, including mid-grant.
- Reset values:
  - grant=4'b0000, grant_idx=2'd0, grant_valid=0, timeout=0.
  - state=IDLE, last=2'd3 (so client 0 has top priority first), hold_cnt=0.
- States:
  - IDLE: no grant outstanding.
  - GRANT: one owner holds the resource.
- IDLE:
  - If req != 0 at a clock edge, the arbiter picks the first set req[i] searching (last+1), (last+2), (last+3), (last+4) mod 4.
  - On that edge: grant=(1<<i), grant_idx=i, grant_valid=1, hold_cnt=1, state -> GRANT.
  - Latency from req sampled to grant visible: 1 cycle.
  - If req=0, the arbiter stays in IDLE with outputs at their idle values.
  - done is ignored in IDLE.
- GRANT, owner o. Release conditions, evaluated at each edge:
  - (a) done=1.
  - (b) req[o]=0.
  - (c) MAX_HOLD!=0 and hold_cnt==MAX_HOLD.
- On release:
  - grant=0, grant_valid=0, last=o, hold_cnt=0, state -> IDLE.
  - grant_idx keeps o; it is don't-care while grant_valid=0.
- Timeout pulse:
  - timeout=1 for one cycle only when (c) causes the release and neither (a) nor (b) is true.
  - If (a) or (b) is true on the same edge, the release is normal and timeout=0.
- Otherwise, while in GRANT:
  - hold_cnt increments, saturating at 255.
  - grant and grant_idx hold.
  - Requests from other clients do not pre-empt the owner.
- Turnaround:
  - Every release is followed by at least one IDLE cycle with grant=0.
  - The next grant appears on the edge after the release edge, at the earliest.
  - A client whose grant was just released may be re-granted only if no other client is requesting, because the search starts at o+1.
- Invariants:
  - grant is always one-hot or zero.
  - grant == (grant_valid ? 1<<grant_idx : 0).
  - timeout is never high for 2 consecutive cycles.
- Reset mid-grant:
  - All outputs return to their reset values asynchronously.
  - Round-robin history is lost: last=3.

Test Plan:
- Reset, then req=4'b0000 for 5 cycles -> grant=0, grant_valid=0, timeout=0 throughout.
- req=4'b1111 held, done pulsed 1 cycle after each grant -> grant sequence 0001, (idle), 0010, (idle), 0100, (idle), 1000, (idle), 0001; grant_idx 0,1,2,3,0.
- req=4'b0100 only, held, done=0, MAX_HOLD=8 -> grant=0100 for exactly 8 cycles, timeout=1 on the release edge, 1 idle cycle, then re-grant 0100.
- Owner 1 holds while req[1] drops and req[3]=1 -> next edge grant=0, the following edge grant=1000, grant_idx=3, timeout=0.
- done=1 on the same edge that hold_cnt==MAX_HOLD -> normal release, timeout=0.
- rst asserted mid-grant, between clock edges, with grant=0010 -> grant=0, grant_valid=0 immediately. After deassert with req=4'b1010 -> first grant=0010 (search from last=3 gives 0, then 1).
